// File: rtl/clock_alarm.sv
// MM:SS alarm unit beside the CLOCK1 counter: set/arm/ring/snooze FSM plus an hourly chime stretcher.
// Outputs are registered-state decodes; keys are synchronised and edge-detected before use.
module clock_alarm #(
  parameter int RING_SECS  = 30,
  parameter int SNOOZE_MIN = 5,
  parameter int CHIME_CYC  = 25000000
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic [3:0] sec1,
  input  logic [2:0] sec10,
  input  logic [3:0] min1,
  input  logic [2:0] min10,
  input  logic       CA,
  input  logic [1:0] KEY,
  input  logic [9:0] SW,
  output logic [3:0] am1,
  output logic [2:0] am10,
  output logic       ARMED,
  output logic       RING,
  output logic       CHIME
);

  localparam int CW = $clog2(CHIME_CYC + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_SET, S_ARMED, S_RINGING, S_SNOOZE
  } state_t;

  state_t          r_state, w_state_nxt;
  logic [3:0]      r_am1, w_am1_nxt;
  logic [2:0]      r_am10, w_am10_nxt;
  logic [7:0]      r_ring_cnt, w_ring_nxt;
  logic [3:0]      r_snz_cnt, w_snz_nxt;
  logic [CW-1:0]   r_chime_cnt;
  logic [1:0]      r_key_s1, r_key_s2, r_key_q;
  logic [3:0]      r_sec1_q;
  logic            r_match_q;

  logic [1:0]      w_kp;
  logic            w_sec_tick, w_min_tick, w_match, w_trig;
  logic            w_unused;

  // SW[7:0] carry no function in this block
  assign w_unused   = ^SW[7:0];

  assign w_kp       = r_key_q & ~r_key_s2;
  assign w_sec_tick = (sec1 != r_sec1_q);
  assign w_min_tick = w_sec_tick && (sec10 == 3'd0) && (sec1 == 4'd0);
  assign w_match    = (min10 == r_am10) && (min1 == r_am1) && (sec10 == 3'd0) && (sec1 == 4'd0);
  assign w_trig     = w_match & ~r_match_q;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_key_s1  <= 2'b11;
      r_key_s2  <= 2'b11;
      r_key_q   <= 2'b11;
      r_sec1_q  <= 4'd0;
      r_match_q <= 1'b0;
    end else begin
      r_key_s1  <= KEY;
      r_key_s2  <= r_key_s1;
      r_key_q   <= r_key_s2;
      r_sec1_q  <= sec1;
      r_match_q <= w_match;
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_state    <= S_IDLE;
      r_am1      <= 4'd0;
      r_am10     <= 3'd0;
      r_ring_cnt <= 8'd0;
      r_snz_cnt  <= 4'd0;
    end else begin
      r_state    <= w_state_nxt;
      r_am1      <= w_am1_nxt;
      r_am10     <= w_am10_nxt;
      r_ring_cnt <= w_ring_nxt;
      r_snz_cnt  <= w_snz_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_am1_nxt   = r_am1;
    w_am10_nxt  = r_am10;
    w_ring_nxt  = r_ring_cnt;
    w_snz_nxt   = r_snz_cnt;

    if (r_state == S_SET) begin
      if (w_kp[0]) w_am1_nxt  = (r_am1 == 4'd9)  ? 4'd0 : r_am1 + 4'd1;
      if (w_kp[1]) w_am10_nxt = (r_am10 == 3'd5) ? 3'd0 : r_am10 + 3'd1;
    end

    // Switches override everything; keys before timers inside each state
    if (SW[9]) begin
      w_state_nxt = S_SET;
    end else if (!SW[8]) begin
      w_state_nxt = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE, S_SET: w_state_nxt = S_ARMED;
        S_ARMED: begin
          if (w_trig) begin
            w_state_nxt = S_RINGING;
            w_ring_nxt  = 8'd0;
          end
        end
        S_RINGING: begin
          if (w_kp[1]) begin
            w_state_nxt = S_ARMED;
          end else if (w_kp[0]) begin
            w_state_nxt = S_SNOOZE;
            w_snz_nxt   = 4'd0;
          end else if (w_sec_tick) begin
            if (r_ring_cnt == 8'(RING_SECS - 1)) w_state_nxt = S_ARMED;
            else                                 w_ring_nxt  = r_ring_cnt + 8'd1;
          end
        end
        S_SNOOZE: begin
          if (w_kp[1]) begin
            w_state_nxt = S_ARMED;
          end else if (w_min_tick) begin
            if (r_snz_cnt == 4'(SNOOZE_MIN - 1)) begin
              w_state_nxt = S_RINGING;
              w_ring_nxt  = 8'd0;
            end else begin
              w_snz_nxt = r_snz_cnt + 4'd1;
            end
          end
        end
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  // CA reloads the full pulse length even while a chime is already running
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST)                   r_chime_cnt <= '0;
    else if (CA)                r_chime_cnt <= CW'(CHIME_CYC);
    else if (r_chime_cnt != '0) r_chime_cnt <= r_chime_cnt - 1'b1;
  end

  assign am1   = r_am1;
  assign am10  = r_am10;
  assign ARMED = (r_state == S_ARMED) || (r_state == S_RINGING) || (r_state == S_SNOOZE);
  assign RING  = (r_state == S_RINGING);
  assign CHIME = (r_chime_cnt != '0);

endmodule

// File: tb/tb_clock_alarm.sv
// Directed bench for clock_alarm: expected output vectors {am10,am1,ARMED,RING,CHIME} are queued then checked.
module tb_clock_alarm;
  logic       CLK = 1'b0;
  logic       RST;
  logic [3:0] sec1, min1;
  logic [2:0] sec10, min10;
  logic       CA;
  logic [1:0] KEY;
  logic [9:0] SW;
  logic [3:0] am1;
  logic [2:0] am10;
  logic       ARMED, RING, CHIME;

  int errors = 0;
  int checks = 0;
  logic [9:0] exp_q[$];
  string      tag_q[$];

  clock_alarm #(.RING_SECS(30), .SNOOZE_MIN(5), .CHIME_CYC(4)) dut (
    .CLK(CLK), .RST(RST), .sec1(sec1), .sec10(sec10), .min1(min1), .min10(min10),
    .CA(CA), .KEY(KEY), .SW(SW), .am1(am1), .am10(am10),
    .ARMED(ARMED), .RING(RING), .CHIME(CHIME)
  );

  always #5 CLK = ~CLK;

  function automatic logic [9:0] v(input logic [2:0] a10, input logic [3:0] a1,
                                   input logic armed, input logic ring, input logic chime);
    return {a10, a1, armed, ring, chime};
  endfunction

  task automatic expect_out(input string tag, input logic [9:0] e);
    exp_q.push_back(e);
    tag_q.push_back(tag);
  endtask

  task automatic check_out();
    logic [9:0] obs, e;
    string tag;
    obs = {am10, am1, ARMED, RING, CHIME};
    e   = exp_q.pop_front();
    tag = tag_q.pop_front();
    checks++;
    assert (obs === e) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, e);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic set_t(input logic [2:0] m10, input logic [3:0] m1,
                       input logic [2:0] s10, input logic [3:0] s1);
    min10 = m10; min1 = m1; sec10 = s10; sec1 = s1;
  endtask

  task automatic press(input logic [1:0] m);
    KEY = ~m;
    tick(3);
    KEY = 2'b11;
    tick(3);
  endtask

  task automatic ring_at_1200();
    set_t(3'd1, 4'd1, 3'd5, 4'd9); tick(1);
    set_t(3'd1, 4'd2, 3'd0, 4'd0); tick(1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    // T1 reset
    RST = 1'b0; KEY = 2'b00; CA = 1'b1; SW = 10'h000;
    set_t(3'd0, 4'd5, 3'd3, 4'd0);
    expect_out("reset_hold", v(0, 0, 0, 0, 0));
    tick(3); check_out();
    @(negedge CLK);
    RST = 1'b1; KEY = 2'b11; CA = 1'b0;
    expect_out("reset_release_idle", v(0, 0, 0, 0, 0));
    tick(2); check_out();

    // T2 set
    SW = 10'h200;
    expect_out("enter_set", v(0, 0, 0, 0, 0));
    tick(1); check_out();
    for (int i = 0; i < 9; i++) press(2'b01);
    expect_out("am1_9", v(0, 9, 0, 0, 0)); check_out();
    press(2'b01);
    expect_out("am1_wrap", v(0, 0, 0, 0, 0)); check_out();
    press(2'b01); press(2'b01);
    for (int i = 0; i < 5; i++) press(2'b10);
    expect_out("am10_5", v(5, 2, 0, 0, 0)); check_out();
    press(2'b10); press(2'b10);
    expect_out("am_12", v(1, 2, 0, 0, 0)); check_out();
    press(2'b11);
    expect_out("both_keys_set", v(2, 3, 0, 0, 0)); check_out();
    for (int i = 0; i < 9; i++) press(2'b01);
    for (int i = 0; i < 5; i++) press(2'b10);
    expect_out("am_back_12", v(1, 2, 0, 0, 0)); check_out();
    SW = 10'h100;
    expect_out("armed", v(1, 2, 1, 0, 0));
    tick(1); check_out();
    press(2'b01);
    expect_out("key_ignored_armed", v(1, 2, 1, 0, 0)); check_out();

    // T3 trigger and ring timeout
    set_t(3'd1, 4'd1, 3'd5, 4'd9); tick(1);
    set_t(3'd1, 4'd2, 3'd0, 4'd0);
    expect_out("match_before_edge", v(1, 2, 1, 0, 0)); check_out();
    expect_out("ring_after_edge", v(1, 2, 1, 1, 0));
    tick(1); check_out();
    for (int s = 1; s <= 29; s++) begin
      set_t(3'd1, 4'd2, 3'(s / 10), 4'(s % 10));
      tick(1);
    end
    expect_out("ring_29_secs", v(1, 2, 1, 1, 0)); check_out();
    set_t(3'd1, 4'd2, 3'd3, 4'd0);
    expect_out("ring_timeout", v(1, 2, 1, 0, 0));
    tick(1); check_out();
    expect_out("no_rering", v(1, 2, 1, 0, 0));
    tick(20); check_out();

    // T4 snooze
    ring_at_1200();
    expect_out("ring2", v(1, 2, 1, 1, 0)); check_out();
    press(2'b01);
    expect_out("snooze", v(1, 2, 1, 0, 0)); check_out();
    for (int k = 1; k <= 4; k++) begin
      set_t(3'd1, 4'(2 + k), 3'd0, 4'd1); tick(1);
      set_t(3'd1, 4'(2 + k), 3'd0, 4'd0); tick(1);
    end
    expect_out("snooze_4min", v(1, 2, 1, 0, 0)); check_out();
    set_t(3'd1, 4'd7, 3'd0, 4'd1); tick(1);
    set_t(3'd1, 4'd7, 3'd0, 4'd0);
    expect_out("snooze_expire", v(1, 2, 1, 1, 0));
    tick(1); check_out();
    press(2'b10);
    expect_out("stop_after_snooze", v(1, 2, 1, 0, 0)); check_out();

    // T5 overrides
    ring_at_1200();
    expect_out("ring3", v(1, 2, 1, 1, 0)); check_out();
    press(2'b11);
    expect_out("stop_wins", v(1, 2, 1, 0, 0)); check_out();
    expect_out("held_match_no_retrig", v(1, 2, 1, 0, 0));
    tick(10); check_out();
    ring_at_1200();
    SW = 10'h000;
    expect_out("sw8_off_before_edge", v(1, 2, 1, 1, 0)); check_out();
    expect_out("sw8_off_idle", v(1, 2, 0, 0, 0));
    tick(1); check_out();
    SW = 10'h100;
    expect_out("rearm_no_trig", v(1, 2, 1, 0, 0));
    tick(1); check_out();
    ring_at_1200();
    SW = 10'h300;
    expect_out("sw9_set_from_ring", v(1, 2, 0, 0, 0));
    tick(1); check_out();
    SW = 10'h100; tick(1);

    // T6 chime
    CA = 1'b1; tick(1); CA = 1'b0;
    expect_out("chime_start", v(1, 2, 1, 0, 1)); check_out();
    expect_out("chime_4th", v(1, 2, 1, 0, 1));
    tick(3); check_out();
    expect_out("chime_end", v(1, 2, 1, 0, 0));
    tick(1); check_out();
    CA = 1'b1; tick(1); CA = 1'b0;
    tick(2);
    CA = 1'b1; tick(1); CA = 1'b0;
    expect_out("chime_restart_last", v(1, 2, 1, 0, 1));
    tick(3); check_out();
    expect_out("chime_restart_end", v(1, 2, 1, 0, 0));
    tick(1); check_out();
    CA = 1'b1; tick(1); CA = 1'b0;
    #2 RST = 1'b0;
    expect_out("async_reset", v(0, 0, 0, 0, 0));
    #1 check_out();
    @(negedge CLK);
    RST = 1'b1;
    expect_out("post_reset_setting_lost", v(0, 0, 1, 0, 0));
    tick(2); check_out();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
